dm_mmio_bridge: RTL and testbench

// - Sits on the core data-memory port, between core dm_* outputs and dual_port_mem port 1.
// - Decodes a 16-byte MMIO window. Hits are serviced locally; all other accesses pass through to memory unchanged.
// - MMIO window provides a byte TX FIFO (console), a status register and a TOHOST register.
// - TOHOST drives the bench's done/pass verdict, in place of polling debug_port/ecall.

---
 rtl/dm_mmio_bridge.sv | 177 +++++++++++++++++
 tb/tb_dm_mmio_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_mmio_bridge.sv
// Data-memory port bridge: passes core accesses through to memory and services a 16-byte
// MMIO window (console TX FIFO, STATUS, TOHOST, CYCLE). Optional cycle counter: DM_MMIO_CYCLE_CNT_EN.
module dm_mmio_bridge #(
  parameter logic [31:0] MMIO_BASE  = 32'h8000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DRAIN_DIV  = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dm_wen_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_din_i,
  output logic [31:0] dm_dout_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  input  logic [31:0] mem_dout_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        done_o,
  output logic        pass_o,
  output logic [31:0] tohost_o,
  output logic [1:0]  drain_state_o
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = (DRAIN_DIV > 3) ? $clog2(DRAIN_DIV + 1) : 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } drain_state_e;

  drain_state_e    state;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      ovf_cnt;
  logic            hit;
  logic [1:0]      reg_sel;
  logic            push;
  logic            push_ok;
  logic            pop;
  logic            full;
  logic            empty;
  logic [31:0]     status;
  logic [31:0]     cycle_rd;
  logic [31:0]     rd_mux;
  logic            hit_q;
  logic [31:0]     mmio_rdata_q;

  assign hit        = (dm_addr_i[31:4] == MMIO_BASE[31:4]);
  assign reg_sel    = dm_addr_i[3:2];
  assign mem_wen_o  = dm_wen_i & ~hit;
  assign mem_addr_o = dm_addr_i;
  assign mem_din_o  = dm_din_i;
  assign dm_dout_o  = hit_q ? mmio_rdata_q : mem_dout_i;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = dm_wen_i & hit & (reg_sel == 2'd0);
  // The FSM only sits in SEND with a nonempty FIFO, so pop never underflows.
  assign pop     = (state == SEND) & tx_ready_i;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr] <= dm_din_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      if (push && !push_ok && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  // The IDLE cycle after GAP is the last of the DRAIN_DIV low cycles between bytes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state      <= SEND;
            tx_valid_o <= 1'b1;
            tx_data_o  <= fifo_mem[rd_ptr];
          end
        end
        SEND: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            if (DRAIN_DIV > 1) begin
              gap_cnt <= GW'(DRAIN_DIV);
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt <= GW'(2)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign drain_state_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_o   <= 1'b0;
      pass_o   <= 1'b0;
      tohost_o <= '0;
    end else if (dm_wen_i && hit && reg_sel == 2'd2 && !done_o) begin
      done_o   <= 1'b1;
      pass_o   <= (dm_din_i == 32'h1);
      tohost_o <= dm_din_i;
    end
  end

`ifdef DM_MMIO_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                 cycle_cnt <= '0;
    else if (dm_wen_i && hit && reg_sel == 2'd3)  cycle_cnt <= '0;
    else                                          cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign cycle_rd = cycle_cnt;
`else
  assign cycle_rd = '0;
`endif

  assign status = {16'b0, ovf_cnt, 5'(count), 1'b0, full, empty};

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = tohost_o;
      2'd3:    rd_mux = cycle_rd;
      default: rd_mux = '0;
    endcase
  end

  // Read data is captured at the address cycle so MMIO matches memory's one-cycle latency.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_q        <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      hit_q        <= hit;
      mmio_rdata_q <= hit ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Self-checking bench for dm_mmio_bridge: a queue-based reference model feeds read and TX
// scoreboards; directed cases cover gap timing, overflow, TOHOST and reset during SEND.
`timescale 1ns/1ps
module tb_dm_mmio_bridge;

  localparam logic [31:0] BASE  = 32'h8000_1000;
  localparam int          DEPTH = 8;
  localparam int          GAPC  = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        dm_wen_i = 1'b0;
  logic [31:0] dm_addr_i = 32'h8000_0000;
  logic [31:0] dm_din_i = '0;
  logic [31:0] dm_dout_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_din_o;
  logic [31:0] mem_dout_i;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic        done_o;
  logic        pass_o;
  logic [31:0] tohost_o;
  logic [1:0]  drain_state_o;

  dm_mmio_bridge #(.MMIO_BASE(BASE), .FIFO_DEPTH(DEPTH), .DRAIN_DIV(GAPC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .dm_wen_i(dm_wen_i), .dm_addr_i(dm_addr_i),
    .dm_din_i(dm_din_i), .dm_dout_o(dm_dout_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
    .tx_ready_i(tx_ready_i), .done_o(done_o), .pass_o(pass_o), .tohost_o(tohost_o),
    .drain_state_o(drain_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- memory behind port 1 ----------------
  logic [31:0] mem_arr [256];
  always @(posedge clk_i) begin
    if (mem_wen_o) mem_arr[mem_addr_o[9:2]] <= mem_din_o;
    mem_dout_i <= mem_arr[mem_addr_o[9:2]];
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic        rd_tag = 1'b0;
  logic        rd_tag_q = 1'b0;

  // reference model state
  logic [31:0] ref_mem [256];
  int          m_cnt = 0;
  int          m_ovf = 0;
  bit          m_done = 0;
  logic [31:0] m_tohost = '0;
  logic [31:0] m_cyc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd15);
  endfunction

  // Rules from the register map evaluated on the model state seen during the address cycle.
  task automatic model_step();
    logic [31:0] exp;
    int          idx;
    bit          hit;
    if (!rst_n_i) begin
      m_cnt = 0; m_ovf = 0; m_done = 0; m_tohost = '0; m_cyc = '0;
      tx_exp_q.delete();
      return;
    end
    idx = int'(dm_addr_i[9:2]);
    hit = in_window(dm_addr_i);
    if (rd_tag) begin
      if (!hit) exp = ref_mem[idx];
      else begin
        case (int'(dm_addr_i - BASE) / 4)
          1:       exp = 32'(m_ovf * 256 + m_cnt * 8 + (m_cnt == DEPTH ? 2 : 0) + (m_cnt == 0 ? 1 : 0));
          2:       exp = m_tohost;
`ifdef DM_MMIO_CYCLE_CNT_EN
          3:       exp = m_cyc;
`endif
          default: exp = 32'h0;
        endcase
      end
      rd_exp_q.push_back(exp);
    end
    if (tx_valid_o && tx_ready_i) m_cnt--;
    if (dm_wen_i) begin
      if (!hit) ref_mem[idx] = dm_din_i;
      else if (dm_addr_i[3:2] == 2'd0) begin
        if (m_cnt < DEPTH) begin
          m_cnt++;
          tx_exp_q.push_back(dm_din_i[7:0]);
        end else if (m_ovf < 255) m_ovf++;
      end else if (dm_addr_i[3:2] == 2'd2 && !m_done) begin
        m_done = 1;
        m_tohost = dm_din_i;
      end
    end
    if (dm_wen_i && hit && dm_addr_i[3:2] == 2'd3) m_cyc = '0;
    else m_cyc = m_cyc + 32'd1;
  endtask

  initial forever begin
    @(posedge clk_i);
    model_step();
  end

  always @(posedge clk_i) rd_tag_q <= rd_tag;

  // ---------------- monitors ----------------
  always @(negedge clk_i) begin
    logic [31:0] e;
    if (rst_n_i && rd_tag_q) begin
      if (rd_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_data: got %h expected no pending read", dm_dout_o);
      end else begin
        e = rd_exp_q.pop_front();
        check("rd_data", dm_dout_o, e);
      end
    end
  end

  always @(negedge clk_i) begin
    logic [7:0] e;
    if (rst_n_i && tx_valid_o && tx_ready_i) begin
      if (tx_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL tx_data: got %h expected no byte", tx_data_o);
      end else begin
        e = tx_exp_q.pop_front();
        check("tx_data", {24'b0, tx_data_o}, {24'b0, e});
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_n_i && dm_wen_i) begin
      check("mem_wen", {31'b0, mem_wen_o}, {31'b0, !in_window(dm_addr_i)});
      check("mem_din", mem_din_o, dm_din_i);
      check("mem_addr", mem_addr_o, dm_addr_i);
    end
  end

  // ---------------- driver tasks (one bus cycle each) ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk_i); #1;
    dm_wen_i = 1'b1; dm_addr_i = a; dm_din_i = d; rd_tag = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    @(posedge clk_i); #1;
    dm_wen_i = 1'b0; dm_addr_i = a; dm_din_i = '0; rd_tag = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      dm_wen_i = 1'b0; dm_addr_i = 32'h8000_0000; dm_din_i = '0; rd_tag = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle(1);
    rst_n_i = 1'b0;
    idle(3);
    rst_n_i = 1'b1;
    idle(1);
  endtask

  task automatic drain(input int budget);
    int k;
    tx_ready_i = 1'b1;
    k = 0;
    while ((tx_exp_q.size() != 0 || tx_valid_o) && k < budget) begin
      idle(1);
      k++;
    end
    idle(GAPC + 3);
    check("drain_left", 32'(tx_exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int          acc_cyc [2];
  logic [7:0]  acc_dat [2];
  int          n_acc;
  int          op;
  logic [31:0] a;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end

    // reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_pass", {31'b0, pass_o}, 32'd0);
    check("rst_tohost", tohost_o, 32'd0);
    check("rst_dout_follows_mem", dm_dout_o, mem_dout_i);
    #1 rst_n_i = 1'b1;
    idle(2);

    // memory pass-through, including addresses just outside the window
    wr(32'h8000_0100, 32'hDEAD_BEEF);
    rd(32'h8000_0100);
    idle(1);
    @(negedge clk_i);
    check("mem_readback", dm_dout_o, 32'hDEAD_BEEF);
    wr(32'h8000_0FFC, 32'h1234_5678);
    wr(32'h8000_1010, 32'hCAFE_F00D);
    rd(32'h8000_0FFC);
    rd(32'h8000_1010);
    idle(1);

    // two bytes back-to-back: spacing between acceptances
    tx_ready_i = 1'b1;
    wr(BASE, 32'h4F);
    wr(BASE, 32'h4B);
    idle(1);
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (tx_valid_o && tx_ready_i) begin
        if (n_acc < 2) begin
          acc_cyc[n_acc] = i;
          acc_dat[n_acc] = tx_data_o;
        end
        n_acc++;
      end
    end
    check("ok_count", 32'(n_acc), 32'd2);
    check("ok_byte0", {24'b0, acc_dat[0]}, 32'h4F);
    check("ok_byte1", {24'b0, acc_dat[1]}, 32'h4B);
    check("ok_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(GAPC + 1));

    // overflow: 10 bytes into a stalled sink
    tx_ready_i = 1'b0;
    idle(1);
    for (int i = 0; i < 10; i++) wr(BASE, 32'h30 + 32'(i));
    rd(BASE + 32'd4);
    idle(1);
    @(negedge clk_i);
    check("status_full", dm_dout_o, 32'h0000_0242);
    drain(200);

    // TOHOST pass, then ignored second write
    wr(BASE + 32'd8, 32'h1);
    idle(1);
    @(negedge clk_i);
    check("done_after_1", {31'b0, done_o}, 32'd1);
    check("pass_after_1", {31'b0, pass_o}, 32'd1);
    wr(BASE + 32'd8, 32'h3);
    rd(BASE + 32'd8);
    idle(1);
    @(negedge clk_i);
    check("tohost_sticky", tohost_o, 32'h1);
    check("pass_sticky", {31'b0, pass_o}, 32'd1);

    // fresh run: failing TOHOST value
    do_reset();
    check("done_cleared", {31'b0, done_o}, 32'd0);
    wr(BASE + 32'd8, 32'h5);
    idle(1);
    @(negedge clk_i);
    check("done_after_5", {31'b0, done_o}, 32'd1);
    check("pass_after_5", {31'b0, pass_o}, 32'd0);
    check("tohost_5", tohost_o, 32'h5);

    // asynchronous reset while a byte is being offered
    tx_ready_i = 1'b0;
    wr(BASE, 32'hA1);
    wr(BASE, 32'hA2);
    wr(BASE, 32'hA3);
    idle(1);
    for (int k = 0; k < 20 && !tx_valid_o; k++) idle(1);
    check("send_before_rst", {31'b0, tx_valid_o}, 32'd1);
    #3 rst_n_i = 1'b0;
    #1;
    check("rst_mid_valid", {31'b0, tx_valid_o}, 32'd0);
    check("rst_mid_data", {24'b0, tx_data_o}, 32'd0);
    check("rst_mid_state", {30'b0, drain_state_o}, 32'd0);
    idle(2);
    rst_n_i = 1'b1;
    idle(1);
    rd(BASE + 32'd4);
    idle(1);
    @(negedge clk_i);
    check("status_after_rst", dm_dout_o, 32'h0000_0001);
    check("no_tx_after_rst", {31'b0, tx_valid_o}, 32'd0);

    // CYCLE register: clear, wait, read; TXDATA reads zero
    wr(BASE + 32'd12, 32'h0);
    idle(5);
    rd(BASE + 32'd12);
    rd(BASE);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      tx_ready_i = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 9);
      a = 32'h8000_0000 + {22'b0, 8'($urandom_range(0, 255)), 2'b0};
      case (op)
        0, 1:    wr(a, $urandom);
        2, 3:    rd(a);
        4, 5:    wr(BASE, 32'($urandom_range(0, 255)));
        6:       rd(BASE + 32'd4);
        7:       rd(BASE + 32'd8);
        8:       rd(BASE + {28'b0, 2'($urandom_range(0, 3)), 2'b0});
        default: idle(1);
      endcase
    end
    idle(1);
    drain(400);
    idle(2);
    check("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
